// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write port shared by the boot loader
// and its environment. master = byte source / memory side, slave = loader.
interface imem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: length-prefixed big-endian byte stream to 32-bit word writes.
// Optional trailing 32-bit additive checksum is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          cpu_rst,
  output logic          done,
  output logic          error
);

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CSUM,
`endif
    DONE,
    ERR
  } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t IMAGE_END = CSUM;
`else
  localparam state_t IMAGE_END = DONE;
`endif

  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

  state_t      state, state_next;
  logic [7:0]  hdr_hi;
  logic [15:0] n_words;
  logic [15:0] word_cnt;
  logic [1:0]  byte_cnt;
  logic [23:0] asm_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] sum_q;
`endif

  logic        hs;
  logic        word_done;
  logic        restart;
  logic [15:0] hdr_count;
  logic [31:0] word;

  assign bus.in_ready   = !rst && (state != DONE) && (state != ERR);
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;

  assign hs        = bus.in_valid && bus.in_ready;
  assign hdr_count = {hdr_hi, bus.in_data};
  assign word      = {asm_q, bus.in_data};

  // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_next = state;
    word_done  = 1'b0;
    restart    = 1'b0;
    unique case (state)
      HDR_HI: if (hs) state_next = HDR_LO;
      HDR_LO: begin
        if (hs) begin
          if ({1'b0, hdr_count} > MAX_W) state_next = ERR;
          else if (hdr_count == 16'd0)   state_next = IMAGE_END;
          else                           state_next = DATA;
        end
      end
      DATA: begin
        if (hs && byte_cnt == 2'd3) begin
          word_done = 1'b1;
          if (word_cnt + 16'd1 == n_words) state_next = IMAGE_END;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: begin
        if (hs && byte_cnt == 2'd3) state_next = (word == sum_q) ? DONE : ERR;
      end
`endif
      DONE, ERR: begin
        if (start) begin
          state_next = HDR_HI;
          restart    = 1'b1;
        end
      end
      default: state_next = HDR_HI;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HDR_HI;
      hdr_hi   <= '0;
      n_words  <= '0;
      word_cnt <= '0;
      byte_cnt <= '0;
      asm_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= BASE_ADDR;
      wdata_q  <= '0;
      cpu_rst  <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q    <= '0;
`endif
    end else begin
      state   <= state_next;
      we_q    <= word_done;
      done    <= (state_next == DONE);
      error   <= (state_next == ERR);
      cpu_rst <= (state_next != DONE);

      if (hs) begin
        if (state == HDR_HI) hdr_hi  <= bus.in_data;
        if (state == HDR_LO) n_words <= hdr_count;
        if (state != HDR_HI && state != HDR_LO) begin
          asm_q    <= word[23:0];
          byte_cnt <= byte_cnt + 2'd1;
        end
      end

      // The write port holds its last address/data between strobes.
      if (word_done) begin
        addr_q   <= BASE_ADDR + {14'd0, word_cnt, 2'b00};
        wdata_q  <= word;
        word_cnt <= word_cnt + 16'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_q    <= sum_q + word;
`endif
      end

      if (restart) begin
        byte_cnt <= '0;
        word_cnt <= '0;
        n_words  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_q    <= '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader: images are generated and their expected
// memory writes and final status derived from the stream format, then compared to the DUT.
module tb_imem_loader;
  localparam logic [31:0] BASE = 32'h0040_0000;
  localparam int          MAXW = 256;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic cpu_rst, done, error;

  imem_loader_if ifc ();

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bus     (ifc.slave),
    .cpu_rst (cpu_rst),
    .done    (done),
    .error   (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Write monitor: every strobe is recorded with its cycle number.
  logic [63:0] wr_q[$];
  int          wr_cyc[$];
  int          cyc = 0;
  bit          prev_we = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (ifc.imem_we === 1'b1) begin
      check("we_single_cycle", 64'(prev_we), 64'd0);
      wr_q.push_back({ifc.imem_addr, ifc.imem_wdata});
      wr_cyc.push_back(cyc);
    end
    prev_we = (ifc.imem_we === 1'b1);
  end

  // Offers one byte; density<0 toggles in_valid every cycle. Returns at the accepting posedge.
  task automatic send_byte(input logic [7:0] b, input int density, output bit ok);
    bit hs;
    ok = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      ifc.in_data = b;
      if (density < 0) ifc.in_valid = cyc[0];
      else             ifc.in_valid = ($urandom_range(99) < density);
      #1;
      if (t == 0) check("ready_while_loading", 64'(ifc.in_ready), 64'd1);
      hs = ifc.in_valid && ifc.in_ready;
      @(posedge clk);
      if (hs) begin
        ok = 1'b1;
        return;
      end
    end
    ifc.in_valid = 1'b0;
  endtask

  task automatic run_image(input logic [31:0] words[$], input int n_hdr, input int density,
                           input bit bad_csum);
    logic [7:0]  bytes[$];
    logic [31:0] sum;
    logic [31:0] csum;
    bit          ok, hdr_ok, exp_err, exp_we;
    sum = '0;
    bytes.push_back(8'(n_hdr >> 8));
    bytes.push_back(8'(n_hdr));
    hdr_ok = (n_hdr <= MAXW);
    if (hdr_ok) begin
      foreach (words[i]) begin
        for (int s = 24; s >= 0; s -= 8) bytes.push_back(8'(words[i] >> s));
        sum += words[i];
      end
      if (CSUM_EN) begin
        csum = sum + 32'(bad_csum);
        for (int s = 24; s >= 0; s -= 8) bytes.push_back(8'(csum >> s));
      end
    end
    exp_err = !hdr_ok || (CSUM_EN && bad_csum);
    exp_we  = hdr_ok && (n_hdr > 0) && !CSUM_EN;

    wr_q.delete();
    wr_cyc.delete();
    foreach (bytes[i]) begin
      send_byte(bytes[i], density, ok);
      if (!ok) begin
        check("handshake_timeout", 64'd0, 64'd1);
        return;
      end
    end
    #1;
    check("final_we", 64'(ifc.imem_we), 64'(exp_we));
    check("done", 64'(done), 64'(!exp_err));
    check("error", 64'(error), 64'(exp_err));
    check("cpu_rst", 64'(cpu_rst), 64'(exp_err));
    check("ready_terminal", 64'(ifc.in_ready), 64'd0);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("write_count", 64'(wr_q.size()), hdr_ok ? 64'(words.size()) : 64'd0);
    foreach (wr_q[i]) begin
      if (i < words.size())
        check("write_addr_data", wr_q[i], {BASE + 32'(4 * i), words[i]});
    end
  endtask

  task automatic pulse_start(input bit with_valid);
    @(negedge clk);
    start = 1'b1;
    ifc.in_valid = with_valid;
    ifc.in_data  = 8'hFF;
    @(posedge clk);
    #1;
    check("start_cpu_rst", 64'(cpu_rst), 64'd1);
    check("start_done", 64'(done), 64'd0);
    check("start_error", 64'(error), 64'd0);
    check("start_ready", 64'(ifc.in_ready), 64'd1);
    @(negedge clk);
    start = 1'b0;
    ifc.in_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] w[$];
    bit ok;
    int n;
    ifc.in_valid = 1'b0;
    ifc.in_data  = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    check("rst_we", 64'(ifc.imem_we), 64'd0);
    check("rst_addr", 64'(ifc.imem_addr), 64'(BASE));
    check("rst_wdata", 64'(ifc.imem_wdata), 64'd0);
    check("rst_cpu_rst", 64'(cpu_rst), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_ready", 64'(ifc.in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Full-rate reference image: writes must be exactly four cycles apart.
    w = '{32'h2008_0005, 32'h0109_5020};
    run_image(w, 2, 100, 1'b0);
    if (wr_cyc.size() == 2) check("write_spacing", 64'(wr_cyc[1] - wr_cyc[0]), 64'd4);

    pulse_start(1'b0);
    run_image(w, 2, -1, 1'b0);

    // start together with a byte: the byte must be ignored or the next header is corrupted.
    pulse_start(1'b1);
    w = {};
    run_image(w, 257, 100, 1'b0);

    pulse_start(1'b0);
    run_image(w, 0, 100, 1'b0);
    pulse_start(1'b0);
    w = '{32'hDEAD_BEEF};
    run_image(w, 1, 100, 1'b0);

    pulse_start(1'b0);
    w = '{32'h0000_0001, 32'h0000_0002};
    run_image(w, 2, 100, 1'b0);
    pulse_start(1'b0);
    run_image(w, 2, 100, 1'b1);

    pulse_start(1'b0);
    w = {};
    for (int i = 0; i < MAXW; i++) w.push_back($urandom);
    run_image(w, MAXW, 100, 1'b0);

    // Reset in the middle of word 1 abandons it without a write.
    pulse_start(1'b0);
    wr_q.delete();
    foreach (w[i]) if (i < 0) ok = 1'b0;
    send_byte(8'h00, 100, ok);
    send_byte(8'h02, 100, ok);
    send_byte(8'hAA, 100, ok);
    send_byte(8'hBB, 100, ok);
    @(negedge clk);
    rst = 1'b1;
    ifc.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_ready", 64'(ifc.in_ready), 64'd0);
    check("midrst_cpu_rst", 64'(cpu_rst), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_no_write", 64'(wr_q.size()), 64'd0);
    w = '{32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_F0F0};
    run_image(w, 3, 70, 1'b0);

    for (int r = 0; r < 15; r++) begin
      pulse_start(1'b0);
      w = {};
      n = ($urandom_range(7) == 0) ? int'($urandom_range(300, 257)) : int'($urandom_range(8));
      if (n <= MAXW) for (int i = 0; i < n; i++) w.push_back($urandom);
      run_image(w, n, int'($urandom_range(100, 30)), 1'($urandom_range(1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=%0d exp=finished", cyc);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the MIPS core's instruction memory. It accepts a byte stream over a valid/ready handshake, frames it as a length-prefixed program image, and assembles big-endian 32-bit words. Each word is written into the instruction memory write port at consecutive word addresses. The processor is held in reset until the image has loaded cleanly, so the loader sits between the off-chip byte source and the core's `InstructionMemory`/`rst` inputs.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h0000_0000: byte address of the first written word; must be word-aligned.
- `MAX_WORDS`, default 256: instruction memory capacity in words; a larger header count is an error.

Ports:
- `clk` input 1: single clock. Rising edge only.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: single-cycle pulse; restarts loading from `DONE` or `ERR`.
- `in_valid` input 1: byte source has data.
- `in_data` input 8: stream byte.
- `in_ready` output 1: loader accepts a byte this cycle.
- `imem_we` output 1: instruction memory write strobe, one cycle per word.
- `imem_addr` output 32: byte address of the word being written.
- `imem_wdata` output 32: assembled instruction word.
- `cpu_rst` output 1: reset to the MIPS core; high unless the loader is in `DONE`.
- `done` output 1: image loaded and verified.
- `error` output 1: load aborted.

## Operation
- Stream format: 2-byte word count N (MSB first), then N words of 4 bytes each (MSB first). With `IMEM_LOADER_CHECKSUM_EN`, a 4-byte checksum follows (MSB first).
- A handshake occurs when `in_valid && in_ready`. Only a handshake advances state or counters.
- FSM states: `HDR_HI`, `HDR_LO`, `DATA`, `CSUM` (macro only), `DONE`, `ERR`.
- `HDR_HI` → `HDR_LO` on handshake; the byte is latched as N[15:8].
- On the `HDR_LO` handshake:
  - N > `MAX_WORDS` → `ERR`.
  - N = 0 → `CSUM` if the macro is defined, else `DONE`.
  - Otherwise → `DATA`.
- In `DATA`, a 2-bit byte counter shifts bytes into a 32-bit assembly register. The 4th handshake completes a word, and a 16-bit word counter k increments.
- After word N-1 completes: → `CSUM` with the macro, else → `DONE`.
- `in_ready` = 1 in `HDR_HI`, `HDR_LO`, `DATA` and `CSUM`. It is 0 in `DONE` and `ERR`, and 0 while `rst` is high.
- `start` in `DONE` or `ERR` → `HDR_HI` and clears all counters. `start` in any other state is ignored.
- Address arithmetic: `imem_addr` = `BASE_ADDR` + 4·k, a 32-bit wrapping add. `imem_addr` and `imem_wdata` hold their last values when `imem_we` = 0.
- `rst` mid-load abandons the partial word and returns to `HDR_HI`. Words already written are not erased.

## Timing
- Reset values:
  - state `HDR_HI`
  - `imem_we`=0, `imem_addr`=`BASE_ADDR`, `imem_wdata`=0
  - `cpu_rst`=1, `done`=0, `error`=0
  - counters 0
- `imem_we`, `imem_addr` and `imem_wdata` are registered. `imem_we` goes high for exactly one cycle, in the cycle after the 4th byte handshake of a word.
- Back-to-back words at full rate produce a write every 4 cycles. Maximum throughput is one byte per cycle.
- `done` and `error` are registered. They assert in the cycle after the handshake that causes the transition; for data-terminated images this is the same cycle as the final `imem_we`.
- `cpu_rst` deasserts in that same cycle and reasserts in the cycle after an accepted `start`.
- Simultaneous `start` and `in_valid` in `DONE`: the `start` is taken and the byte is not accepted, because `in_ready` is 0 that cycle.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - A running 32-bit sum (mod 2^32) of all N words is kept.
  - After the last word, the `CSUM` state takes 4 bytes.
  - On the 4th `CSUM` handshake: match → `DONE`, mismatch → `ERR`. Words already written remain in memory, and `cpu_rst` stays high in `ERR`.
- `IMEM_LOADER_CHECKSUM_EN` undefined: the `CSUM` state and the sum register are absent, and the last data word goes directly to `DONE`.

## Test plan
- Reset, then stream 00 02 | 20 08 00 05 | 01 09 50 20 at one byte per cycle → two `imem_we` pulses: addr 0x0 data 0x20080005, then addr 0x4 data 0x01095020. `done`=1 and `cpu_rst`=0 with the 2nd write.
- Same image with `in_valid` toggling every other cycle → identical writes, no duplicates or drops, `in_ready` stays 1 until `DONE`.
- Header 01 01 (N=257) with `MAX_WORDS`=256 → `error`=1 the cycle after the 2nd byte, no `imem_we`, `in_ready`=0, `cpu_rst`=1.
- Header 00 00 (macro off) → `done`=1 with no writes. Then pulse `start` → `cpu_rst`=1 and `done`=0 next cycle; a reload of 1 word writes addr `BASE_ADDR`.
- Macro on, words 0x00000001 and 0x00000002, checksum 00 00 00 03 → `done`. Repeat with checksum 00 00 00 04 → `error`=1, `cpu_rst` held 1.
- Assert `rst` after 2 bytes of word 1 → no `imem_we`, state `HDR_HI`. A fresh full image then loads correctly from `BASE_ADDR`.
